// File: rtl/bcd_seg_display.sv
// Binary-to-BCD (sequential double-dabble) converter driving a 2-digit multiplexed 7-segment display.
// Optional LEADING_ZERO_BLANK_EN: blank the tens digit when it is zero.
module bcd_seg_display #(
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned DIV_W    = 14
) (
  input  logic       clk,
  input  logic       xrst,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       valid,
  output logic       ovf
);

  localparam int unsigned BIN_W = 7;
  localparam int unsigned SR_W  = 19;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state, state_n;
  logic [SR_W-1:0]   sh, sh_n;
  logic [2:0]        iter, iter_n;
  logic [BIN_W-1:0]  cap, cap_n;
  logic [BIN_W-1:0]  last_value, last_value_n;
  logic              force_cnv, force_cnv_n;
  logic [3:0]        tens_n, ones_n;
  logic              valid_n, ovf_n;
  logic [DIV_W-1:0]  prescaler;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] r;
    r = s;
    if (r[18:15] >= 4'd5) r[18:15] = r[18:15] + 4'd3;
    if (r[14:11] >= 4'd5) r[14:11] = r[14:11] + 4'd3;
    if (r[10:7]  >= 4'd5) r[10:7]  = r[10:7]  + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state      <= IDLE;
      sh         <= '0;
      iter       <= '0;
      cap        <= '0;
      last_value <= '0;
      force_cnv  <= 1'b1;
      bcd_tens   <= '0;
      bcd_ones   <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      iter       <= iter_n;
      cap        <= cap_n;
      last_value <= last_value_n;
      force_cnv  <= force_cnv_n;
      bcd_tens   <= tens_n;
      bcd_ones   <= ones_n;
      valid      <= valid_n;
      ovf        <= ovf_n;
    end
  end

  always_comb begin
    state_n      = state;
    sh_n         = sh;
    iter_n       = iter;
    cap_n        = cap;
    last_value_n = last_value;
    force_cnv_n  = force_cnv;
    tens_n       = bcd_tens;
    ones_n       = bcd_ones;
    valid_n      = valid;
    ovf_n        = ovf;
    case (state)
      IDLE: begin
        if ((value != last_value) || force_cnv) begin
          sh_n        = {12'b0, value};
          cap_n       = value;
          force_cnv_n = 1'b0;
          iter_n      = '0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        sh_n   = {dabble(sh)[SR_W-2:0], 1'b0};
        iter_n = iter + 3'd1;
        if (iter == 3'd6) state_n = LATCH;
      end
      LATCH: begin
        tens_n       = sh[14:11];
        ones_n       = sh[10:7];
        ovf_n        = (sh[18:15] != 4'd0);
        valid_n      = 1'b1;
        last_value_n = cap;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Digit scan: toggle the active digit every SCAN_DIV clocks.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      prescaler <= '0;
      dig       <= 2'b01;
    end else if (prescaler == DIV_W'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      dig       <= {dig[0], dig[1]};
    end else begin
      prescaler <= prescaler + DIV_W'(1);
    end
  end

  always_comb begin
    seg = 7'h00;
    if (valid) begin
      if (ovf) begin
        seg = 7'h40;
      end else if (dig[1]) begin
`ifdef LEADING_ZERO_BLANK_EN
        seg = (bcd_tens == 4'd0) ? 7'h00 : seg_pat(bcd_tens);
`else
        seg = seg_pat(bcd_tens);
`endif
      end else begin
        seg = seg_pat(bcd_ones);
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display (SCAN_DIV=4): arithmetic reference model plus directed checks.
module tb_bcd_seg_display;

  logic       clk;
  logic       xrst;
  logic [6:0] value;
  logic [6:0] seg;
  logic [1:0] dig;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       valid;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  bcd_seg_display #(.SCAN_DIV(4), .DIV_W(2)) dut (
    .clk(clk), .xrst(xrst), .value(value), .seg(seg), .dig(dig),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .valid(valid), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a conversion occupies 9 edges from sampling to latch;
  // the scan digit depends only on the number of edges since reset.
  int   m_busy  = 0;
  bit   m_force = 1;
  int   m_last  = 0;
  int   m_cap   = 0;
  int   m_edges = 0;
  bit   m_valid = 0;
  bit   m_ovf   = 0;
  int   m_tens  = 0;
  int   m_ones  = 0;

  always @(posedge clk or posedge xrst) begin
    if (xrst) begin
      m_busy = 0; m_force = 1; m_last = 0; m_cap = 0; m_edges = 0;
      m_valid = 0; m_ovf = 0; m_tens = 0; m_ones = 0;
    end else begin
      m_edges++;
      if (m_busy == 0) begin
        if (int'(value) != m_last || m_force) begin
          m_cap = int'(value); m_force = 0; m_busy = 8;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_tens  = (m_cap / 10) % 10;
          m_ones  = m_cap % 10;
          m_ovf   = (m_cap >= 100);
          m_valid = 1;
          m_last  = m_cap;
        end
      end
    end
  end

  function automatic int digit_pat(input int d);
    int tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  function automatic int model_dig();
    return ((m_edges / 4) % 2) ? 2 : 1;
  endfunction

  function automatic int model_seg();
    if (!m_valid) return 0;
    if (m_ovf) return 7'h40;
    if (model_dig() == 2) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (m_tens == 0) return 0;
`endif
      return digit_pat(m_tens);
    end
    return digit_pat(m_ones);
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!xrst) begin
      check("m_dig",   int'(dig),      model_dig());
      check("m_valid", int'(valid),    int'(m_valid));
      check("m_ovf",   int'(ovf),      int'(m_ovf));
      check("m_tens",  int'(bcd_tens), m_tens);
      check("m_ones",  int'(bcd_ones), m_ones);
      check("m_seg",   int'(seg),      model_seg());
    end
  end

  initial begin
    int n;
    int tens_slot_exp;
    xrst  = 1'b1;
    value = 7'd0;
    tick(3);
    // Reset state
    check("rst_seg",   int'(seg),      0);
    check("rst_dig",   int'(dig),      1);
    check("rst_tens",  int'(bcd_tens), 0);
    check("rst_ones",  int'(bcd_ones), 0);
    check("rst_valid", int'(valid),    0);
    check("rst_ovf",   int'(ovf),      0);
    xrst = 1'b0;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_edges", n, 9);
    check("first_tens", int'(bcd_tens), 0);
    check("first_ones", int'(bcd_ones), 0);
    check("first_ovf",  int'(ovf),      0);

    // value=42: latched on the 9th edge, not before
    value = 7'd42;
    tick(8);
    check("v42_before_tens", int'(bcd_tens), 0);
    tick(1);
    check("v42_tens", int'(bcd_tens), 4);
    check("v42_ones", int'(bcd_ones), 2);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (dig == 2'b10) check("v42_seg_tens", int'(seg), 7'h66);
      else              check("v42_seg_ones", int'(seg), 7'h5B);
    end

    // Sweep 0..127
    for (int v = 0; v < 128; v++) begin
      value = 7'(v);
      tick(9);
      if (v <= 99) begin
        check("sweep_tens", int'(bcd_tens), v / 10);
        check("sweep_ones", int'(bcd_ones), v % 10);
        check("sweep_ovf",  int'(ovf),      0);
      end else begin
        check("sweep_ovf", int'(ovf), 1);
        check("sweep_seg", int'(seg), 7'h40);
      end
    end

    // Change mid-conversion: 15 first, then 99
    value = 7'd15;
    tick(2);
    value = 7'd99;
    tick(7);
    check("mid_first_tens", int'(bcd_tens), 1);
    check("mid_first_ones", int'(bcd_ones), 5);
    tick(8);
    check("mid_hold_ones", int'(bcd_ones), 5);
    tick(1);
    check("mid_second_tens", int'(bcd_tens), 9);
    check("mid_second_ones", int'(bcd_ones), 9);

    // Scan and reset pulse during an in-flight conversion
    n = 0;
    while (dig != 2'b10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scan_reach_tens", int'(dig), 2);
    value = 7'd33;
    tick(2);
    xrst = 1'b1;
    #1;
    check("pulse_dig",   int'(dig),   1);
    check("pulse_valid", int'(valid), 0);
    check("pulse_seg",   int'(seg),   0);
    tick(1);
    xrst = 1'b0;
    tick(3);
    check("scan_hold_ones", int'(dig), 1);
    tick(1);
    check("scan_toggle_tens", int'(dig), 2);
    tick(4);
    check("scan_back_ones", int'(dig), 1);
    check("force_pending_valid", int'(valid), 0);
    tick(1);
    check("force_tens",  int'(bcd_tens), 3);
    check("force_ones",  int'(bcd_ones), 3);
    check("force_valid", int'(valid),    1);

    // Single-digit value and tens-slot rendering
    value = 7'd7;
    tick(9);
    check("v7_ones", int'(bcd_ones), 7);
`ifdef LEADING_ZERO_BLANK_EN
    tens_slot_exp = 0;
`else
    tens_slot_exp = 7'h3F;
`endif
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (dig == 2'b10) check("v7_seg_tens", int'(seg), tens_slot_exp);
      else              check("v7_seg_ones", int'(seg), 7'h07);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
